// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the issue controller's instruction, register-file, ALU,
// memory and performance-counter signals.
interface alu_issue_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [3:0]        rf_raddr1;
    logic [3:0]        rf_raddr2;
    logic [31:0]       rf_rdata1;
    logic [31:0]       rf_rdata2;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic [31:0]       alu_src1;
    logic [31:0]       alu_src2;
    logic [3:0]        alu_op;
    logic [15:0]       alu_imm;
    logic              alu_s;
    logic [3:0]        alu_cond;
    logic [31:0]       alu_result;
    logic [3:0]        alu_flags;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [3:0]        flags;
    logic              retired;
    logic              skipped;
    logic [31:0]       perf_retired;
    logic [31:0]       perf_skipped;

    // Controller side.
    modport master (
        input  instr_valid, instr,
        input  rf_rdata1, rf_rdata2,
        input  alu_result, alu_flags,
        input  mem_ack, mem_rdata,
        output instr_ready,
        output rf_raddr1, rf_raddr2,
        output rf_we, rf_waddr, rf_wdata,
        output alu_src1, alu_src2, alu_op,
        output alu_imm, alu_s, alu_cond,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output flags, retired, skipped,
        output perf_retired, perf_skipped
    );

    // Environment side: instruction source, register file, ALU, memory.
    modport slave (
        output instr_valid, instr,
        output rf_rdata1, rf_rdata2,
        output alu_result, alu_flags,
        output mem_ack, mem_rdata,
        input  instr_ready,
        input  rf_raddr1, rf_raddr2,
        input  rf_we, rf_waddr, rf_wdata,
        input  alu_src1, alu_src2, alu_op,
        input  alu_imm, alu_s, alu_cond,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  flags, retired, skipped,
        input  perf_retired, perf_skipped
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/sequencing controller around the combinational ALU.
// Define ISSUE_PERF_CNT_EN to build the retired/skipped counters.
module alu_issue_ctrl #(
    parameter int MUL_CYCLES = 3,
    parameter int ADDR_W     = 16
) (
    input logic              clk,
    input logic              reset,
    alu_issue_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        MEM,
        WB
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] ir;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic [3:0]  res_fl;
    logic [3:0]  flags_q;
    logic [3:0]  cnt;
    logic        skip;

    logic [3:0]  cond;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;

    logic        cond_ok;
    logic        is_mem;
    logic        is_nox;
    logic        wr_op;
    logic        fl_op;

    assign cond = ir[31:28];
    assign op   = ir[27:24];
    assign rd   = ir[22:19];
    assign rs1  = ir[18:15];
    assign rs2  = ir[14:11];
    assign imm  = ir[15:0];

    assign cond_ok = (cond == 4'd0) || (cond == flags_q);

    // Opcode classes: memory, no-execute, register write, flag update.
    always_comb begin
        is_mem = 1'b0;
        is_nox = 1'b0;
        wr_op  = 1'b0;
        fl_op  = 1'b0;
        unique case (op)
            4'b0000, 4'b0001, 4'b0010,
            4'b1000, 4'b1001, 4'b1010: begin
                wr_op = 1'b1;
                fl_op = 1'b1;
            end
            4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111: wr_op = 1'b1;
            4'b1011: fl_op = 1'b1;
            4'b1100: begin
                is_nox = 1'b1;
                wr_op  = 1'b1;
            end
            4'b1101: begin
                is_mem = 1'b1;
                wr_op  = 1'b1;
            end
            4'b1110: is_mem = 1'b1;
            4'b1111: is_nox = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state sequencing.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.instr_valid) state_nx = READ;
            READ: begin
                if (!cond_ok)    state_nx = WB;
                else if (is_mem) state_nx = MEM;
                else if (is_nox) state_nx = WB;
                else             state_nx = EXEC;
            end
            EXEC: if (cnt == 4'd1) state_nx = WB;
            MEM:  if (bus.mem_ack) state_nx = WB;
            WB:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Instruction, operand, result and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir      <= '0;
            op1     <= '0;
            op2     <= '0;
            res     <= '0;
            res_fl  <= '0;
            flags_q <= '0;
            cnt     <= '0;
            skip    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.instr_valid) ir <= bus.instr;
                READ: begin
                    op1  <= bus.rf_rdata1;
                    op2  <= bus.rf_rdata2;
                    skip <= !cond_ok;
                    cnt  <= (op == 4'b0010) ? 4'(MUL_CYCLES) : 4'd1;
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        res    <= bus.alu_result;
                        res_fl <= bus.alu_flags;
                    end
                end
                MEM: if (bus.mem_ack) res <= bus.mem_rdata;
                WB: if (!skip && fl_op) flags_q <= res_fl;
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = (state == IDLE);

    assign bus.rf_raddr1 = rs1;
    assign bus.rf_raddr2 = rs2;

    assign bus.rf_we    = (state == WB) && !skip && wr_op;
    assign bus.rf_waddr = rd;
    assign bus.rf_wdata = (op == 4'b1100) ? {16'd0, imm} : res;

    assign bus.alu_src1 = op1;
    assign bus.alu_src2 = op2;
    assign bus.alu_op   = op;
    assign bus.alu_imm  = imm;
    assign bus.alu_s    = ir[23];
    assign bus.alu_cond = 4'b0000;

    assign bus.mem_req   = (state == MEM);
    assign bus.mem_we    = (state == MEM) && (op == 4'b1110);
    assign bus.mem_addr  = op1[ADDR_W-1:0];
    assign bus.mem_wdata = op2;

    assign bus.flags   = flags_q;
    assign bus.retired = (state == WB) && !skip;
    assign bus.skipped = (state == WB) && skip;

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_r;
    logic [31:0] perf_s;

    // Completion counters, free-running and wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_r <= '0;
            perf_s <= '0;
        end else begin
            if (bus.retired) perf_r <= perf_r + 32'd1;
            if (bus.skipped) perf_s <= perf_s + 32'd1;
        end
    end

    assign bus.perf_retired = perf_r;
    assign bus.perf_skipped = perf_s;
`else
    assign bus.perf_retired = '0;
    assign bus.perf_skipped = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a register-file,
// ALU and memory model driven from the bench.
module tb_alu_issue_ctrl;

    localparam int MUL_CYC = 3;
    localparam int AW      = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_LDI = 4'b1100;
    localparam logic [3:0] OP_LD  = 4'b1101;
    localparam logic [3:0] OP_ST  = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    logic clk = 1'b0;
    logic reset;

    alu_issue_ctrl_if #(.ADDR_W(AW)) ifc ();

    alu_issue_ctrl #(
        .MUL_CYCLES(MUL_CYC),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    logic [31:0] rf [16];

    assign ifc.rf_rdata1 = rf[ifc.rf_raddr1];
    assign ifc.rf_rdata2 = rf[ifc.rf_raddr2];

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [32:0] sum;
    logic        c;
    logic        v;

    // Reference ALU: ADD, SUB/CMP with borrow as carry, MUL low word.
    always_comb begin
        a   = ifc.alu_src1;
        b   = ifc.alu_src2;
        r   = '0;
        sum = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (ifc.alu_op)
            4'b0001, 4'b1011: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0010: r = a * b;
            default: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[31:0];
                c   = sum[32];
                v   = (a[31] == b[31]) && (r[31] != a[31]);
            end
        endcase
        ifc.alu_result = r;
        ifc.alu_flags  = {r[31], (r == 32'd0), c, v};
    end

    int pass_cnt = 0;
    int total    = 0;

    int          lat;
    int          low;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        ret;
    logic        skp;

    function automatic logic [31:0] enc(
        input logic [3:0] cond,
        input logic [3:0] op,
        input logic [3:0] rd,
        input logic [3:0] rs1,
        input logic [3:0] rs2
    );
        return {cond, op, 1'b0, rd, rs1, rs2, 11'd0};
    endfunction

    function automatic logic [31:0] enc_imm(
        input logic [3:0]  cond,
        input logic [3:0]  op,
        input logic [3:0]  rd,
        input logic [15:0] imm
    );
        return {cond, op, 1'b0, rd, 3'd0, imm};
    endfunction

    // Issue one non-memory instruction and follow it to write-back.
    task automatic run(input logic [31:0] w);
        lat = 0; low = 0; we = 0; wa = 0;
        wd = 0; ret = 0; skp = 0;
        ifc.instr       = w;
        ifc.instr_valid = 1'b1;
        for (int k = 0; k < 20 && !ifc.instr_ready; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!ifc.instr_ready) low++;
            if (ifc.retired || ifc.skipped) begin
                lat = k;
                we  = ifc.rf_we;
                wa  = ifc.rf_waddr;
                wd  = ifc.rf_wdata;
                ret = ifc.retired;
                skp = ifc.skipped;
                break;
            end
            @(posedge clk); #1;
        end
        if (we) rf[wa] = wd;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1 || ifc.mem_req !== 1'b0 ||
            ifc.mem_we !== 1'b0 || ifc.rf_we !== 1'b0) begin
            $display("FAIL reset_ctl: rdy=%b req=%b mwe=%b rwe=%b want 1000",
                     ifc.instr_ready, ifc.mem_req, ifc.mem_we, ifc.rf_we);
        end else pass_cnt++;
        total++;
        if (ifc.retired !== 1'b0 || ifc.skipped !== 1'b0 ||
            ifc.flags !== 4'd0) begin
            $display("FAIL reset_status: ret=%b skp=%b flags=%b want 0 0 0000",
                     ifc.retired, ifc.skipped, ifc.flags);
        end else pass_cnt++;
        total++;
        if (ifc.alu_src1 !== 32'd0 || ifc.mem_addr !== 16'd0 ||
            ifc.rf_wdata !== 32'd0 || ifc.perf_retired !== 32'd0) begin
            $display("FAIL reset_data: src1=%h addr=%h wdata=%h perf=%h want 0",
                     ifc.alu_src1, ifc.mem_addr, ifc.rf_wdata,
                     ifc.perf_retired);
        end else pass_cnt++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf[3] = 32'd0;
        run(enc(4'd0, OP_ADD, 4'd3, 4'd1, 4'd2));
        total++;
        if (lat !== 3) $display("FAIL add_latency: got %0d want 3", lat);
        else pass_cnt++;
        total++;
        if (we !== 1'b1 || wa !== 4'd3 || wd !== 32'd12) begin
            $display("FAIL add_write: we=%b waddr=%0d wdata=%0d want 1 3 12",
                     we, wa, wd);
        end else pass_cnt++;
        total++;
        if (ret !== 1'b1 || skp !== 1'b0 || ifc.flags !== 4'b0000) begin
            $display("FAIL add_retire: ret=%b skp=%b flags=%b want 1 0 0000",
                     ret, skp, ifc.flags);
        end else pass_cnt++;
        total++;
        if (low !== 3) $display("FAIL add_busy: got %0d want 3", low);
        else pass_cnt++;
    endtask

    task automatic test_cond();
        rf[1] = 32'd5;
        rf[2] = 32'd5;
        run(enc(4'd0, OP_CMP, 4'd0, 4'd1, 4'd2));
        total++;
        if (we !== 1'b0 || ret !== 1'b1 || ifc.flags !== 4'b0100) begin
            $display("FAIL cmp_eq: we=%b ret=%b flags=%b want 0 1 0100",
                     we, ret, ifc.flags);
        end else pass_cnt++;
        run(enc(4'b0100, OP_ADD, 4'd4, 4'd1, 4'd2));
        total++;
        if (lat !== 3 || ret !== 1'b1 || we !== 1'b1 || wd !== 32'd10) begin
            $display("FAIL cond_pass: lat=%0d ret=%b we=%b wdata=%0d want 3 1 1 10",
                     lat, ret, we, wd);
        end else pass_cnt++;
        rf[2] = 32'd6;
        run(enc(4'd0, OP_CMP, 4'd0, 4'd1, 4'd2));
        total++;
        if (ifc.flags !== 4'b1010) begin
            $display("FAIL cmp_lt: flags=%b want 1010", ifc.flags);
        end else pass_cnt++;
        rf[5] = 32'h55;
        run(enc(4'b0100, OP_ADD, 4'd5, 4'd1, 4'd2));
        total++;
        if (lat !== 2 || skp !== 1'b1 || ret !== 1'b0 || we !== 1'b0) begin
            $display("FAIL cond_skip: lat=%0d skp=%b ret=%b we=%b want 2 1 0 0",
                     lat, skp, ret, we);
        end else pass_cnt++;
        total++;
        if (ifc.flags !== 4'b1010 || rf[5] !== 32'h55) begin
            $display("FAIL skip_state: flags=%b r5=%h want 1010 55",
                     ifc.flags, rf[5]);
        end else pass_cnt++;
    endtask

    task automatic test_mul();
        int stable;
        stable = 0; lat = 0; low = 0; we = 0; wa = 0; wd = 0;
        rf[6] = 32'd6;
        rf[7] = 32'd7;
        ifc.instr       = enc(4'd0, OP_MUL, 4'd8, 4'd6, 4'd7);
        ifc.instr_valid = 1'b1;
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!ifc.instr_ready) low++;
            if (ifc.retired || ifc.skipped) begin
                lat = k;
                we  = ifc.rf_we;
                wa  = ifc.rf_waddr;
                wd  = ifc.rf_wdata;
                break;
            end
            if (k >= 2 && ifc.alu_src1 == 32'd6 &&
                ifc.alu_src2 == 32'd7 && ifc.alu_op == OP_MUL) begin
                stable++;
            end
            @(posedge clk); #1;
        end
        if (we) rf[wa] = wd;
        @(posedge clk); #1;
        total++;
        if (lat !== 2 + MUL_CYC || stable !== MUL_CYC) begin
            $display("FAIL mul_timing: lat=%0d stable=%0d want %0d %0d",
                     lat, stable, 2 + MUL_CYC, MUL_CYC);
        end else pass_cnt++;
        total++;
        if (we !== 1'b1 || wa !== 4'd8 || wd !== 32'd42) begin
            $display("FAIL mul_write: we=%b waddr=%0d wdata=%0d want 1 8 42",
                     we, wa, wd);
        end else pass_cnt++;
        total++;
        if (low !== 5 || ifc.flags !== 4'b0000) begin
            $display("FAIL mul_busy: low=%0d flags=%b want 5 0000",
                     low, ifc.flags);
        end else pass_cnt++;
    endtask

    task automatic test_imm();
        run(enc_imm(4'd0, OP_LDI, 4'd12, 16'hBEEF));
        total++;
        if (lat !== 2 || we !== 1'b1 || wa !== 4'd12 ||
            wd !== 32'h0000BEEF) begin
            $display("FAIL ldi: lat=%0d we=%b waddr=%0d wdata=%h want 2 1 12 0000beef",
                     lat, we, wa, wd);
        end else pass_cnt++;
        run(enc(4'd0, OP_NOP, 4'd13, 4'd0, 4'd0));
        total++;
        if (lat !== 2 || we !== 1'b0 || ret !== 1'b1) begin
            $display("FAIL nop: lat=%0d we=%b ret=%b want 2 0 1", lat, we, ret);
        end else pass_cnt++;
    endtask

    task automatic test_mem();
        int held;
        held  = 0;
        rf[9]  = 32'd0;
        rf[10] = 32'h0000_0010;
        rf[11] = 32'hCAFE_0001;
        ifc.instr       = enc(4'd0, OP_LD, 4'd9, 4'd10, 4'd0);
        ifc.instr_valid = 1'b1;
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            if (ifc.mem_req && ifc.mem_addr == 16'h0010 && !ifc.mem_we) held++;
            if (k == 3) begin
                ifc.mem_ack   = 1'b1;
                ifc.mem_rdata = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
        end
        ifc.mem_ack   = 1'b0;
        ifc.mem_rdata = 32'd0;
        total++;
        if (held !== 4) $display("FAIL ld_hold: got %0d want 4", held);
        else pass_cnt++;
        total++;
        if (ifc.retired !== 1'b1 || ifc.rf_we !== 1'b1 ||
            ifc.rf_waddr !== 4'd9 || ifc.rf_wdata !== 32'hDEAD_BEEF ||
            ifc.mem_req !== 1'b0) begin
            $display("FAIL ld_wb: ret=%b we=%b waddr=%0d wdata=%h req=%b want 1 1 9 deadbeef 0",
                     ifc.retired, ifc.rf_we, ifc.rf_waddr, ifc.rf_wdata,
                     ifc.mem_req);
        end else pass_cnt++;
        if (ifc.rf_we) rf[ifc.rf_waddr] = ifc.rf_wdata;
        @(posedge clk); #1;
        ifc.instr       = enc(4'd0, OP_ST, 4'd0, 4'd10, 4'd11);
        ifc.instr_valid = 1'b1;
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ifc.mem_req !== 1'b1 || ifc.mem_we !== 1'b1 ||
            ifc.mem_addr !== 16'h0010 || ifc.mem_wdata !== 32'hCAFE_0001) begin
            $display("FAIL st_req: req=%b we=%b addr=%h wdata=%h want 1 1 0010 cafe0001",
                     ifc.mem_req, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata);
        end else pass_cnt++;
        ifc.mem_ack = 1'b1;
        @(posedge clk); #1;
        ifc.mem_ack = 1'b0;
        total++;
        if (ifc.retired !== 1'b1 || ifc.rf_we !== 1'b0) begin
            $display("FAIL st_wb: ret=%b rf_we=%b want 1 0",
                     ifc.retired, ifc.rf_we);
        end else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int rets;
        rets = 0;
        rf[1] = 32'd5;
        rf[2] = 32'd6;
        run(enc(4'd0, OP_CMP, 4'd0, 4'd1, 4'd2));
        total++;
        if (ifc.flags !== 4'b1010) begin
            $display("FAIL abort_pre: flags=%b want 1010", ifc.flags);
        end else pass_cnt++;
        ifc.instr       = enc(4'd0, OP_LD, 4'd9, 4'd10, 4'd0);
        ifc.instr_valid = 1'b1;
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++;
        if (ifc.mem_req !== 1'b0 || ifc.retired !== 1'b0 ||
            ifc.rf_we !== 1'b0) begin
            $display("FAIL abort_now: req=%b ret=%b we=%b want 0 0 0",
                     ifc.mem_req, ifc.retired, ifc.rf_we);
        end else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (ifc.instr_ready !== 1'b1 || ifc.flags !== 4'b0000) begin
            $display("FAIL abort_idle: rdy=%b flags=%b want 1 0000",
                     ifc.instr_ready, ifc.flags);
        end else pass_cnt++;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ifc.retired || ifc.skipped || ifc.mem_req) rets++;
        end
        total++;
        if (rets !== 0) $display("FAIL abort_quiet: got %0d want 0", rets);
        else pass_cnt++;
    endtask

    task automatic test_perf();
        logic [31:0] exp_r;
        logic [31:0] exp_s;
        int          nskip;
`ifdef ISSUE_PERF_CNT_EN
        exp_r = 32'd3;
        exp_s = 32'd2;
`else
        exp_r = 32'd0;
        exp_s = 32'd0;
`endif
        nskip = 0;
        rf[1] = 32'd5;
        rf[2] = 32'd6;
        run(enc(4'd0, OP_ADD, 4'd13, 4'd1, 4'd2));
        run(enc(4'd0, OP_ADD, 4'd1, 4'd1, 4'd2));
        total++;
        if (we !== 1'b1 || wa !== 4'd1 || wd !== 32'd11) begin
            $display("FAIL rd_eq_rs1: we=%b waddr=%0d wdata=%0d want 1 1 11",
                     we, wa, wd);
        end else pass_cnt++;
        run(enc(4'd0, OP_CMP, 4'd0, 4'd1, 4'd2));
        for (int k = 0; k < 2; k++) begin
            run(enc(4'b0100, OP_ADD, 4'd14, 4'd1, 4'd2));
            if (skp) nskip++;
        end
        total++;
        if (nskip !== 2) $display("FAIL perf_skips: got %0d want 2", nskip);
        else pass_cnt++;
        total++;
        if (ifc.perf_retired !== exp_r || ifc.perf_skipped !== exp_s) begin
            $display("FAIL perf_cnt: ret=%0d skp=%0d want %0d %0d",
                     ifc.perf_retired, ifc.perf_skipped, exp_r, exp_s);
        end else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        reset           = 1'b1;
        ifc.instr_valid = 1'b0;
        ifc.instr       = 32'd0;
        ifc.mem_ack     = 1'b0;
        ifc.mem_rdata   = 32'd0;
        test_reset();
        test_add();
        test_cond();
        test_mul();
        test_imm();
        test_mem();
        test_abort();
        test_perf();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
